// File: rtl/desserializador_8bits.sv
// Serial-in/parallel-out converter with valid/ready on both sides and a double-buffered output.
// Optional even-parity framing is enabled with the DESSERIALIZADOR_PARIDADE_EN macro.
module desserializador_8bits #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
`ifdef DESSERIALIZADOR_PARIDADE_EN
  localparam int unsigned LAST     = WIDTH,
`else
  localparam int unsigned LAST     = WIDTH - 1,
`endif
  localparam int unsigned CW       = $clog2(LAST + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
`ifdef DESSERIALIZADOR_PARIDADE_EN
  output logic             erro_paridade,
`endif
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_dout;
  logic [CW-1:0]    r_count;
  logic             r_valid;

  logic             w_last;
  logic             w_accept;
  logic             w_done;
  logic             w_load;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_word;

  assign w_last = (r_count == CW'(LAST));

  // Only the closing bit of a frame can be stalled, and only while the buffered word is held.
  assign din_ready = !clr && !(w_last && r_valid && !dout_ready);
  assign w_accept  = din_valid && din_ready;
  assign w_done    = w_accept && w_last;

  assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], din}
                                        : {din, r_shift[WIDTH-1:1]};

`ifdef DESSERIALIZADOR_PARIDADE_EN
  logic w_par_ok;
  logic r_perr;

  // The parity bit is checked against the already-assembled data, never shifted in.
  assign w_par_ok      = ~(^{r_shift, din});
  assign w_shift_en    = w_accept && !w_last;
  assign w_word        = r_shift;
  assign w_load        = w_done && w_par_ok;
  assign erro_paridade = r_perr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_done && !w_par_ok;
    end
  end
`else
  assign w_shift_en = w_accept;
  assign w_word     = w_shift_nxt;
  assign w_load     = w_done;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_shift <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift <= w_shift_nxt;
      end
      if (w_accept) begin
        r_count <= w_last ? '0 : r_count + 1'b1;
      end
      // A word completing on a consume edge replaces the old one without a bubble.
      if (w_load) begin
        r_dout  <= w_word;
        r_valid <= 1'b1;
      end else if (dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign bit_count  = r_count;

endmodule

// File: tb/tb_desserializador_8bits.sv
// Randomised bench for desserializador_8bits: an MSB-first and an LSB-first instance share
// stimulus and are compared against a frame-level reference model.
module tb_desserializador_8bits;

  localparam int W = 8;
`ifdef DESSERIALIZADOR_PARIDADE_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif
  localparam int CW = $clog2(NB);

  logic clk = 1'b0;
  logic clr, din, din_valid, dout_ready;
  logic          rdy_m, rdy_l, val_m, val_l;
  logic [W-1:0]  dout_m, dout_l;
  logic [CW-1:0] cnt_m, cnt_l;
  logic          err_m, err_l;

  always #5 clk = ~clk;

  desserializador_8bits #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .dout(dout_m), .dout_valid(val_m), .dout_ready(dout_ready),
`ifdef DESSERIALIZADOR_PARIDADE_EN
    .erro_paridade(err_m),
`endif
    .bit_count(cnt_m)
  );

  desserializador_8bits #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .dout(dout_l), .dout_valid(val_l), .dout_ready(dout_ready),
`ifdef DESSERIALIZADOR_PARIDADE_EN
    .erro_paridade(err_l),
`endif
    .bit_count(cnt_l)
  );

`ifndef DESSERIALIZADOR_PARIDADE_EN
  assign err_m = 1'b0;
  assign err_l = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame bits collected in arrival order, word built arithmetically.
  int           m_cnt;
  bit           m_valid;
  bit           m_err;
  logic [W-1:0] m_dout[2];
  bit           m_bits[NB];

  function automatic logic [W-1:0] word_of(input bit msb_first);
    logic [W-1:0] res = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) res[W-1-i] = m_bits[i];
      else           res[i]     = m_bits[i];
    end
    return res;
  endfunction

  function automatic bit exp_ready();
    return !clr && !(m_cnt == NB - 1 && m_valid && !dout_ready);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_valid = 0; m_err = 0;
    m_dout[0] = '0; m_dout[1] = '0;
  endtask

  task automatic model_edge();
    bit new_word = 0;
    bit acc = din_valid && exp_ready();
    m_err = 0;
    if (acc) begin
      m_bits[m_cnt] = din;
      if (m_cnt == NB - 1) begin
        bit par = 0;
        for (int i = 0; i < NB; i++) par ^= m_bits[i];
        m_cnt = 0;
        if (!PAR || par == 0) begin
          m_dout[0] = word_of(1);
          m_dout[1] = word_of(0);
          new_word  = 1;
        end else begin
          m_err = 1;
        end
      end else begin
        m_cnt++;
      end
    end
    if (new_word)        m_valid = 1;
    else if (dout_ready) m_valid = 0;
  endtask

  task automatic check_outputs();
    check_val("dout_msb", 32'(dout_m), 32'(m_dout[0]));
    check_val("dout_lsb", 32'(dout_l), 32'(m_dout[1]));
    check_val("valid_msb", 32'(val_m), 32'(m_valid));
    check_val("valid_lsb", 32'(val_l), 32'(m_valid));
    check_val("count_msb", 32'(cnt_m), 32'(m_cnt));
    check_val("count_lsb", 32'(cnt_l), 32'(m_cnt));
    check_val("ready_msb", 32'(rdy_m), 32'(exp_ready()));
    check_val("ready_lsb", 32'(rdy_l), 32'(exp_ready()));
    if (PAR) begin
      check_val("perr_msb", 32'(err_m), 32'(m_err));
      check_val("perr_lsb", 32'(err_l), 32'(m_err));
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check, then advance the model.
  task automatic step(input logic d, input logic v, input logic r);
    @(negedge clk);
    din = d; din_valid = v; dout_ready = r;
    #1;
    check_outputs();
    model_edge();
  endtask

  task automatic send_raw(input logic [NB-1:0] f, input logic r);
    for (int i = NB - 1; i >= 0; i--) step(f[i], 1'b1, r);
  endtask

  function automatic logic [NB-1:0] frame(input logic [W-1:0] w);
    logic [8:0] f = PAR ? {w, ^w} : {1'b0, w};
    return f[NB-1:0];
  endfunction

  task automatic async_clr();
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #2 clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] f;
    clr = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    model_reset();
    #12;
    check_outputs();
    clr = 1'b0;

    // Bits 1,0,1,0,0,1,0,1 give A5 in both bit orders.
    send_raw(frame(8'hA5), 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_val("p1_dout_msb", 32'(dout_m), 32'h A5);
    check_val("p1_dout_lsb", 32'(dout_l), 32'h A5);
    check_val("p1_valid", 32'(val_m), 32'd1);
    check_val("p1_count", 32'(cnt_m), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check_val("p1_valid_drop", 32'(val_m), 32'd0);

    // Bits 0,0,0,0,1,1,1,1.
    send_raw(frame(8'h0F), 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("p2_dout_lsb", 32'(dout_l), 32'h F0);
    check_val("p2_dout_msb", 32'(dout_m), 32'h 0F);

    // Backpressure on the closing bit while the previous word is held.
    f = frame(8'hBB);
    for (int i = NB - 1; i >= 1; i--) step(f[i], 1'b1, 1'b0);
    step(f[0], 1'b1, 1'b0);
    check_val("p3_ready_low", 32'(rdy_m), 32'd0);
    check_val("p3_held", 32'(dout_m), 32'h 0F);
    step(f[0], 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("p3_dout", 32'(dout_m), 32'h BB);
    check_val("p3_valid", 32'(val_m), 32'd1);

    // Gaps between bits.
    f = frame(8'hE5);
    for (int i = NB - 1; i >= 0; i--) begin
      step(f[i], 1'b1, 1'b1);
      step(1'($urandom), 1'b0, 1'b1);
    end
    check_val("p4_dout", 32'(dout_m), 32'h E5);

    // Asynchronous clear mid-word and with a pending word.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    async_clr();
    check_val("p5_count_clr", 32'(cnt_m), 32'd0);
    send_raw(frame(8'h3C), 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_val("p5_pending", 32'(val_m), 32'd1);
    async_clr();
    check_val("p5_valid_clr", 32'(val_m), 32'd0);
    check_val("p5_dout_clr", 32'(dout_m), 32'd0);
    send_raw(frame(8'h5A), 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("p5_clean", 32'(dout_m), 32'h 5A);

`ifdef DESSERIALIZADOR_PARIDADE_EN
    step(1'b0, 1'b0, 1'b1);
    send_raw({8'hA5, 1'b0}, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_val("p6_good", 32'(dout_m), 32'h A5);
    send_raw({8'hA5, 1'b1}, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_val("p6_err", 32'(err_m), 32'd1);
    check_val("p6_no_valid", 32'(val_m), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check_val("p6_err_pulse", 32'(err_m), 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) async_clr();
      else step(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
